// File: rtl/grid_scle_source.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grid_scle_source : table-driven paired grid/scale AXI-Stream frame source.
// Optional GRID_SOURCE_TID_EN: tid carries per-stream frame count. Rev 1.0
// ---------------------------------------------------------------------------
module grid_scle_source #(
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_WIDTH = 16,
  parameter int GRID_POINTS = 8,
  parameter int ADDR_WIDTH  = $clog2(GRID_POINTS),
  parameter int FRAME_WIDTH = 16,
  parameter int ID_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]  cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0]  cfg_wr_grid,
  input  logic [SCALE_WIDTH-1:0] cfg_wr_scle,
  input  logic [ADDR_WIDTH:0]    cfg_len,
  output logic                   cfg_busy,
  input  logic [FRAME_WIDTH-1:0] s_axis_cmd_tdata,
  input  logic                   s_axis_cmd_tvalid,
  output logic                   s_axis_cmd_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_grid_tdata,
  output logic                   m_axis_grid_tvalid,
  input  logic                   m_axis_grid_tready,
  output logic                   m_axis_grid_tlast,
  output logic [ID_WIDTH-1:0]    m_axis_grid_tid,
  output logic [SCALE_WIDTH-1:0] m_axis_scle_tdata,
  output logic                   m_axis_scle_tvalid,
  input  logic                   m_axis_scle_tready,
  output logic                   m_axis_scle_tlast,
  output logic [ID_WIDTH-1:0]    m_axis_scle_tid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(GRID_POINTS);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

  logic [0:0]             state_q, state_d;
  logic                   cmd_rdy_q;
  logic [FRAME_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH:0]    len_q, len_d;
  logic [DATA_WIDTH-1:0]  grid_mem_q [GRID_POINTS];
  logic [SCALE_WIDTH-1:0] scle_mem_q [GRID_POINTS];

  logic [ADDR_WIDTH-1:0]  g_idx_q, g_idx_d, s_idx_q, s_idx_d;
  logic [FRAME_WIDTH-1:0] g_frm_q, g_frm_d, s_frm_q, s_frm_d;
  logic                   g_vld_q, g_vld_d, s_vld_q, s_vld_d;
  logic                   g_last_q, g_last_d, s_last_q, s_last_d;
  logic [DATA_WIDTH-1:0]  g_data_q, g_data_d;
  logic [SCALE_WIDTH-1:0] s_data_q, s_data_d;

  logic                   w_wr_ok, w_cmd_acc, w_cmd_run;
  logic [ADDR_WIDTH:0]    w_len_sel, w_len_m1;
  logic [DATA_WIDTH-1:0]  w_grid_first;
  logic [SCALE_WIDTH-1:0] w_scle_first;

  assign w_wr_ok   = cfg_wr_en && (state_q == IDLE) && ({1'b0, cfg_wr_addr} < LEN_MAX);
  assign w_cmd_acc = s_axis_cmd_tvalid && cmd_rdy_q;
  assign w_cmd_run = w_cmd_acc && (s_axis_cmd_tdata != '0);
  assign w_len_sel = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;
  assign w_len_m1  = len_q - LEN_ONE;

  // A write landing with the command must already be visible in the first beat.
  assign w_grid_first = (w_wr_ok && (cfg_wr_addr == '0)) ? cfg_wr_grid : grid_mem_q[0];
  assign w_scle_first = (w_wr_ok && (cfg_wr_addr == '0)) ? cfg_wr_scle : scle_mem_q[0];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    len_d   = len_q;
    if (state_q == IDLE) begin
      if (w_cmd_acc) begin
        n_d   = s_axis_cmd_tdata;
        len_d = w_len_sel;
      end
      if (w_cmd_run) state_d = RUN;
    end else if (!g_vld_q && !s_vld_q) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    g_idx_d  = g_idx_q;
    g_frm_d  = g_frm_q;
    g_vld_d  = g_vld_q;
    g_last_d = g_last_q;
    g_data_d = g_data_q;
    if (state_q == IDLE) begin
      if (w_cmd_run) begin
        g_idx_d  = '0;
        g_frm_d  = '0;
        g_vld_d  = 1'b1;
        g_last_d = (w_len_sel == LEN_ONE);
        g_data_d = w_grid_first;
      end
    end else if (g_vld_q && m_axis_grid_tready) begin
      if (g_last_q) begin
        g_idx_d = '0;
        g_frm_d = g_frm_q + 1'b1;
      end else begin
        g_idx_d = g_idx_q + 1'b1;
      end
      g_vld_d  = (g_frm_d != n_q);
      g_last_d = g_vld_d && ({1'b0, g_idx_d} == w_len_m1);
      g_data_d = grid_mem_q[g_idx_d];
    end
  end

  always_comb begin
    s_idx_d  = s_idx_q;
    s_frm_d  = s_frm_q;
    s_vld_d  = s_vld_q;
    s_last_d = s_last_q;
    s_data_d = s_data_q;
    if (state_q == IDLE) begin
      if (w_cmd_run) begin
        s_idx_d  = '0;
        s_frm_d  = '0;
        s_vld_d  = 1'b1;
        s_last_d = (w_len_sel == LEN_ONE);
        s_data_d = w_scle_first;
      end
    end else if (s_vld_q && m_axis_scle_tready) begin
      if (s_last_q) begin
        s_idx_d = '0;
        s_frm_d = s_frm_q + 1'b1;
      end else begin
        s_idx_d = s_idx_q + 1'b1;
      end
      s_vld_d  = (s_frm_d != n_q);
      s_last_d = s_vld_d && ({1'b0, s_idx_d} == w_len_m1);
      s_data_d = scle_mem_q[s_idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_rdy_q <= 1'b0;
      n_q       <= '0;
      len_q     <= '0;
      for (int i = 0; i < GRID_POINTS; i++) begin
        grid_mem_q[i] <= '0;
        scle_mem_q[i] <= '0;
      end
      g_idx_q  <= '0;  g_frm_q  <= '0;  g_vld_q  <= 1'b0;
      g_last_q <= 1'b0; g_data_q <= '0;
      s_idx_q  <= '0;  s_frm_q  <= '0;  s_vld_q  <= 1'b0;
      s_last_q <= 1'b0; s_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_rdy_q <= (state_d == IDLE);
      n_q       <= n_d;
      len_q     <= len_d;
      if (w_wr_ok) begin
        grid_mem_q[cfg_wr_addr] <= cfg_wr_grid;
        scle_mem_q[cfg_wr_addr] <= cfg_wr_scle;
      end
      g_idx_q  <= g_idx_d;  g_frm_q  <= g_frm_d;  g_vld_q  <= g_vld_d;
      g_last_q <= g_last_d; g_data_q <= g_data_d;
      s_idx_q  <= s_idx_d;  s_frm_q  <= s_frm_d;  s_vld_q  <= s_vld_d;
      s_last_q <= s_last_d; s_data_q <= s_data_d;
    end
  end

`ifdef GRID_SOURCE_TID_EN
  logic [ID_WIDTH-1:0] g_tid_q, s_tid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_tid_q <= '0;
      s_tid_q <= '0;
    end else begin
      g_tid_q <= ID_WIDTH'(g_frm_d);
      s_tid_q <= ID_WIDTH'(s_frm_d);
    end
  end
  assign m_axis_grid_tid = g_tid_q;
  assign m_axis_scle_tid = s_tid_q;
`else
  assign m_axis_grid_tid = '0;
  assign m_axis_scle_tid = '0;
`endif

  assign cfg_busy           = (state_q == RUN);
  assign s_axis_cmd_tready  = cmd_rdy_q;
  assign m_axis_grid_tdata  = g_data_q;
  assign m_axis_grid_tvalid = g_vld_q;
  assign m_axis_grid_tlast  = g_last_q;
  assign m_axis_scle_tdata  = s_data_q;
  assign m_axis_scle_tvalid = s_vld_q;
  assign m_axis_scle_tlast  = s_last_q;

endmodule
`default_nettype wire
